gen_case_cond: RTL

Input conditioning stage sitting directly upstream of the parameter-selected `q = d` stage. It synchronises a raw asynchronous level `din` into the `clk` domain. It then conditions the level according to a compile-time `MODE` chosen with a generate case: plain register, debounce, pulse stretch or toggle. Its `q` drives the downstream stage's `d` input.

---
 rtl/gen_case_cond_pkg.sv | 20 ++
 rtl/gen_case_sync.sv | 30 +++
 rtl/gen_case_cond.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gen_case_cond_pkg.sv
// gen_case_cond_pkg
// Shared constants and types for the gen_case_cond input conditioning stage.
//   MODE_*    : values accepted by the MODE parameter of gen_case_cond
//   db_state_t: debounce FSM states
//   EVT_W     : width of the optional saturating event counter
package gen_case_cond_pkg;

  localparam int MODE_SYNC     = 0;
  localparam int MODE_DEBOUNCE = 1;
  localparam int MODE_STRETCH  = 2;
  localparam int MODE_TOGGLE   = 3;

  localparam int EVT_W = 8;

  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_CHECK = 1'b1
  } db_state_t;

endpackage

// File: rtl/gen_case_sync.sv
// gen_case_sync
// N-stage reset-to-0 synchroniser for a single asynchronous level.
// Ports:
//   clk   in  clock, rising edge
//   rst_n in  asynchronous active-low reset, clears every stage
//   din   in  raw asynchronous level
//   s     out synchronised level (last stage)
module gen_case_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s
);

  logic [STAGES-1:0] sr;

  // Shifts every cycle; it is never gated by the conditioning enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], din};
    end
  end

  assign s = sr[STAGES-1];

endmodule

// File: rtl/gen_case_cond.sv
// gen_case_cond
// Synchronises a raw asynchronous level into the clk domain and conditions it
// according to the compile-time MODE (selected with a generate case):
//   0 = sync + register, 1 = debounce, 2 = pulse stretch, 3 = toggle on rise.
// Optional feature macro: GEN_CASE_COND_EVT_EN adds the evt_cnt port and its
// 8-bit saturating change counter.
// Ports:
//   clk     in  clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   din     in  raw asynchronous level
//   en      in  conditioning enable; low freezes all conditioning state
//   q       out conditioned, registered level
//   q_chg   out one-cycle pulse in the first cycle q shows a new value
//   evt_cnt out saturating count of q changes (GEN_CASE_COND_EVT_EN only)
module gen_case_cond
  import gen_case_cond_pkg::*;
#(
  parameter int MODE        = 0,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int STRETCH     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  output logic             q,
  output logic             q_chg
`ifdef GEN_CASE_COND_EVT_EN
  ,
  output logic [EVT_W-1:0] evt_cnt
`endif
);

  logic s;
  logic q_next;

  gen_case_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .s     (s)
  );

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gen_case_cond: SYNC_STAGES must be >= 2");
  end

  // Each branch produces q_next; when en is low q_next always equals q, so
  // the shared q register and q_chg hold without further gating.
  case (MODE)
    MODE_SYNC: begin : g_sync
      always_comb begin
        q_next = q;
        if (en) begin
          q_next = s;
        end
      end
    end

    MODE_DEBOUNCE: begin : g_debounce
      if (DB_CYCLES < 1) begin : g_bad_db
        $error("gen_case_cond: DB_CYCLES must be >= 1");
      end

      localparam int CW = $clog2(DB_CYCLES + 1);
      localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

      db_state_t     state, state_nxt;
      logic [CW-1:0] cnt, cnt_nxt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state <= DB_IDLE;
          cnt   <= '0;
        end else if (en) begin
          state <= state_nxt;
          cnt   <= cnt_nxt;
        end
      end

      // cnt counts consecutive enabled samples with s != q; the sample that
      // would bring it to DB_CYCLES commits s instead.
      always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_next    = q;
        if (en) begin
          case (state)
            DB_IDLE: begin
              if (s != q) begin
                if (DB_CYCLES == 1) begin
                  q_next = s;
                end else begin
                  cnt_nxt   = CW'(1);
                  state_nxt = DB_CHECK;
                end
              end
            end
            DB_CHECK: begin
              if (s == q) begin
                cnt_nxt   = '0;
                state_nxt = DB_IDLE;
              end else if (cnt == DB_LAST) begin
                q_next    = s;
                cnt_nxt   = '0;
                state_nxt = DB_IDLE;
              end else begin
                cnt_nxt = cnt + CW'(1);
              end
            end
            default: begin
              cnt_nxt   = '0;
              state_nxt = DB_IDLE;
            end
          endcase
        end
      end
    end

    MODE_STRETCH: begin : g_stretch
      if (STRETCH < 1) begin : g_bad_stretch
        $error("gen_case_cond: STRETCH must be >= 1");
      end

      localparam int CW = $clog2(STRETCH + 1);

      logic [CW-1:0] cnt;
      logic          s_d;
      logic          rise;

      assign rise = s & ~s_d;

      // cnt is the number of further high cycles after the current one; a
      // rise always reloads it, so a retrigger on the last cycle leaves no gap.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
          s_d <= 1'b0;
        end else if (en) begin
          s_d <= s;
          if (rise) begin
            cnt <= CW'(STRETCH - 1);
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
      end

      always_comb begin
        q_next = q;
        if (en) begin
          if (rise) begin
            q_next = 1'b1;
          end else if (cnt == '0) begin
            q_next = 1'b0;
          end
        end
      end
    end

    MODE_TOGGLE: begin : g_toggle
      logic s_d;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_d <= 1'b0;
        end else if (en) begin
          s_d <= s;
        end
      end

      always_comb begin
        q_next = q;
        if (en && s && !s_d) begin
          q_next = ~q;
        end
      end
    end

    default: begin : g_bad_mode
      $error("gen_case_cond: MODE must be 0..3");
      assign q_next = q;
    end
  endcase

  // Output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q     <= 1'b0;
      q_chg <= 1'b0;
    end else begin
      q     <= q_next;
      q_chg <= (q_next != q);
    end
  end

`ifdef GEN_CASE_COND_EVT_EN
  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] v);
    return (v == '1) ? v : v + EVT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
    end else if (q_chg) begin
      evt_cnt <= sat_inc(evt_cnt);
    end
  end
`endif

endmodule
